// File: rtl/bsr_feeder_pkg.sv
// Shared definitions for the bit-serial feeder of the 4-bit bidirectional
// shift register stage: FSM state encoding, direction codes, default width.
package bsr_feeder_pkg;

    localparam int unsigned DEF_WIDTH = 4;

    // Direction codes as seen on the dir output.
    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/bsr_feed_skid.sv
// One-entry pending register for the feeder. Only present when
// BSR_FEED_SKID_EN is defined.
// Ports:
//   clk, rst             clock, async active-low reset
//   in_valid/in_data/in_dir  upstream word offer
//   in_ready             upstream may hand over a word (pending slot empty)
//   bypass               the word goes straight into the shifter this edge
//   pop                  pending word is being moved into the shifter
//   pend_vld/pend_data/pend_dir  pending slot contents
`ifdef BSR_FEED_SKID_EN
module bsr_feed_skid
    import bsr_feeder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    input  logic             bypass,
    input  logic             pop,
    output logic             in_ready,
    output logic             pend_vld,
    output logic [WIDTH-1:0] pend_data,
    output logic             pend_dir
);

    logic push;

    assign in_ready = ~pend_vld;
    // An accepted word that cannot go straight into the shifter parks here.
    assign push     = in_valid & ~pend_vld & ~bypass;

    // Pending slot register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_vld  <= 1'b0;
            pend_data <= '0;
            pend_dir  <= 1'b0;
        end else if (pop) begin
            pend_vld  <= 1'b0;
        end else if (push) begin
            pend_vld  <= 1'b1;
            pend_data <= in_data;
            pend_dir  <= in_dir;
        end
    end

endmodule
`endif

// File: rtl/bsr_feeder.sv
// Serialises parallel words into d/dir/en for the bidirectional shift
// register. LSB-first when dir=0, MSB-first when dir=1, so the word lands
// in its original bit order after WIDTH shifts. hold pauses shifting.
// Optional macro BSR_FEED_SKID_EN adds a one-entry pending register so
// consecutive words run without a gap cycle.
// Ports:
//   clk, rst            clock, async active-low reset
//   in_data, in_dir     parallel word and its shift direction
//   in_valid, in_ready  upstream handshake
//   hold                downstream pause
//   d, dir, en          serial bit, direction, shift enable
//   word_done           last bit of a word presented with en=1
//   busy                word in flight
module bsr_feeder
    import bsr_feeder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             hold,
    output logic             d,
    output logic             dir,
    output logic             en,
    output logic             word_done,
    output logic             busy
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [WIDTH-1:0]   shreg, shreg_nxt;
    logic               dir_r, dir_nxt;

    logic               consume;
    logic               last_bit;
    logic               eow;
    logic               ld_vld;
    logic [WIDTH-1:0]   ld_data;
    logic               ld_dir;

    assign consume  = (state == SHIFT) & ~hold;
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign eow      = consume & last_bit;

`ifdef BSR_FEED_SKID_EN
    logic             pend_vld;
    logic [WIDTH-1:0] pend_data;
    logic             pend_dir;

    bsr_feed_skid #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_dir    (in_dir),
        .bypass    ((state == IDLE) | eow),
        .pop       (eow & pend_vld),
        .in_ready  (in_ready),
        .pend_vld  (pend_vld),
        .pend_data (pend_data),
        .pend_dir  (pend_dir)
    );

    // Pending word wins at end of word; otherwise an offered word goes
    // straight in when idle or on the end-of-word edge.
    assign ld_vld  = pend_vld ? eow : (in_valid & ((state == IDLE) | eow));
    assign ld_data = pend_vld ? pend_data : in_data;
    assign ld_dir  = pend_vld ? pend_dir  : in_dir;
`else
    assign in_ready = (state == IDLE);
    assign ld_vld   = in_valid & in_ready;
    assign ld_data  = in_data;
    assign ld_dir   = in_dir;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
            dir_r <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            shreg <= shreg_nxt;
            dir_r <= dir_nxt;
        end
    end

    // Next-state logic: load a word, advance per consumed bit, finish or reload.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        dir_nxt   = dir_r;
        case (state)
            IDLE: begin
                if (ld_vld) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = '0;
                    shreg_nxt = ld_data;
                    dir_nxt   = ld_dir;
                end
            end
            SHIFT: begin
                if (consume) begin
                    if (last_bit) begin
                        cnt_nxt = '0;
                        if (ld_vld) begin
                            shreg_nxt = ld_data;
                            dir_nxt   = ld_dir;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Serial outputs; dir keeps the last word's direction while idle.
    always_comb begin
        d         = 1'b0;
        en        = consume;
        word_done = eow;
        busy      = (state == SHIFT);
        dir       = dir_r;
        if (state == SHIFT) begin
            d = (dir_r == DIR_MSB_FIRST) ? shreg[CNT_W'(WIDTH - 1) - cnt]
                                         : shreg[cnt];
        end
    end

endmodule

// File: tb/tb_bsr_feeder.sv
// Directed bench for bsr_feeder: bit order, hold, reset, back-to-back words.
module tb_bsr_feeder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] in_data = '0;
    logic       in_dir = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       hold = 1'b0;
    logic       d, dir, en, word_done, busy;

    always #5 clk = ~clk;

    bsr_feeder #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_dir    (in_dir),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .hold      (hold),
        .d         (d),
        .dir       (dir),
        .en        (en),
        .word_done (word_done),
        .busy      (busy)
    );

    int checks = 0;
    int passes = 0;

    // Observation record built by tick().
    logic dq[$];
    int   wd[$];
    int   en_cnt, first_en, last_en, dir_bad, cyc, acc_cyc;
    logic [3:0] sr;
    logic exp_dir;
    logic s_ready, s_busy, s_en, s_d, s_wd;
    logic [7:0] expseq;

    task clear_mon;
        dq.delete();
        wd.delete();
        en_cnt = 0; first_en = -1; last_en = -1; dir_bad = 0; sr = '0;
    endtask

    // Sample at the falling edge, then advance past the next rising edge.
    task tick;
        @(negedge clk);
        s_ready = in_ready; s_busy = busy; s_en = en; s_d = d; s_wd = word_done;
        if (en) begin
            dq.push_back(d);
            if (first_en < 0) first_en = cyc;
            last_en = cyc;
            en_cnt++;
            if (dir !== exp_dir) dir_bad++;
            // Reference shift register: left shift for MSB-first, right for LSB-first.
            sr = dir ? {sr[2:0], d} : {d, sr[3:1]};
        end
        if (word_done) wd.push_back(cyc);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Offer a word; returns just after the accepting edge with in_valid still high.
    task send(input logic [3:0] data, input logic dr);
        bit ok;
        ok = 1'b0;
        in_data = data; in_dir = dr; in_valid = 1'b1;
        for (int i = 0; i < 30 && !ok; i++) begin
            acc_cyc = cyc;
            tick();
            if (s_ready) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            $display("FAIL send_timeout: in_ready never seen for data %h", data);
        end
    endtask

    task drain;
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (!s_busy) done = 1'b1;
        end
        if (!done) begin
            checks++;
            $display("FAIL drain_timeout: busy still %b", s_busy);
        end
    endtask

    task test_reset;
        #2;
        checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else passes++;
        checks++; if (en !== 1'b0) $display("FAIL rst_en: got %b want 0", en); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passes++;
        checks++; if (d !== 1'b0) $display("FAIL rst_d: got %b want 0", d); else passes++;
        checks++; if (dir !== 1'b0) $display("FAIL rst_dir: got %b want 0", dir); else passes++;
        checks++; if (word_done !== 1'b0) $display("FAIL rst_word_done: got %b want 0", word_done); else passes++;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task test_lsb_first;
        clear_mon(); exp_dir = 1'b0; expseq = 8'b0000_1011;
        send(4'b1011, 1'b0);
        in_valid = 1'b0;
        drain();
        checks++; if (en_cnt !== 4) $display("FAIL lsb_en_cnt: got %0d want 4", en_cnt); else passes++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= dq.size() || dq[i] !== expseq[i]) $display("FAIL lsb_bit%0d: got %b want %b", i, (i < dq.size()) ? dq[i] : 1'bx, expseq[i]);
            else passes++;
        end
        checks++; if (first_en !== acc_cyc + 1) $display("FAIL lsb_latency: first en cycle %0d want %0d", first_en, acc_cyc + 1); else passes++;
        checks++; if (wd.size() !== 1 || wd[0] !== last_en) $display("FAIL lsb_word_done: pulses %0d want 1 on cycle %0d", wd.size(), last_en); else passes++;
        checks++; if (dir_bad !== 0) $display("FAIL lsb_dir: %0d en cycles with dir!=0", dir_bad); else passes++;
        checks++; if (sr !== 4'b1011) $display("FAIL lsb_shreg_out: got %b want 1011", sr); else passes++;
        checks++; if (s_en !== 1'b0) $display("FAIL lsb_idle_en: got %b want 0", s_en); else passes++;
    endtask

    task test_msb_first;
        clear_mon(); exp_dir = 1'b1; expseq = 8'b0000_1101;
        send(4'b1011, 1'b1);
        in_valid = 1'b0;
        drain();
        checks++; if (en_cnt !== 4) $display("FAIL msb_en_cnt: got %0d want 4", en_cnt); else passes++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= dq.size() || dq[i] !== expseq[i]) $display("FAIL msb_bit%0d: got %b want %b", i, (i < dq.size()) ? dq[i] : 1'bx, expseq[i]);
            else passes++;
        end
        checks++; if (dir_bad !== 0) $display("FAIL msb_dir: %0d en cycles with dir!=1", dir_bad); else passes++;
        checks++; if (sr !== 4'b1011) $display("FAIL msb_shreg_out: got %b want 1011", sr); else passes++;
        checks++; if (dir !== 1'b1) $display("FAIL msb_dir_held: got %b want 1", dir); else passes++;
    endtask

    task test_hold;
        clear_mon(); exp_dir = 1'b0; expseq = 8'b0000_0100;
        send(4'b0100, 1'b0);
        in_valid = 1'b0;
        tick();
        tick();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (s_en !== 1'b0) $display("FAIL hold_en%0d: got %b want 0", i, s_en); else passes++;
            checks++; if (s_d !== 1'b1 || s_busy !== 1'b1) $display("FAIL hold_frozen%0d: d=%b busy=%b want d=1 busy=1", i, s_d, s_busy); else passes++;
        end
        hold = 1'b0;
        drain();
        checks++; if (en_cnt !== 4) $display("FAIL hold_en_cnt: got %0d want 4", en_cnt); else passes++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= dq.size() || dq[i] !== expseq[i]) $display("FAIL hold_bit%0d: got %b want %b", i, (i < dq.size()) ? dq[i] : 1'bx, expseq[i]);
            else passes++;
        end
        checks++; if (last_en - first_en !== 6) $display("FAIL hold_span: got %0d want 6", last_en - first_en); else passes++;
    endtask

    task test_reset_mid;
        clear_mon(); exp_dir = 1'b0;
        send(4'b1011, 1'b0);
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++; if (en !== 1'b0 || d !== 1'b0) $display("FAIL midrst_en_d: en=%b d=%b want 0 0", en, d); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else passes++;
        checks++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b want 1", in_ready); else passes++;
        #1;
        rst = 1'b1;
        clear_mon(); exp_dir = 1'b1; expseq = 8'b0000_0110;
        send(4'b0110, 1'b1);
        in_valid = 1'b0;
        drain();
        checks++; if (en_cnt !== 4) $display("FAIL midrst_en_cnt: got %0d want 4", en_cnt); else passes++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= dq.size() || dq[i] !== expseq[i]) $display("FAIL midrst_bit%0d: got %b want %b", i, (i < dq.size()) ? dq[i] : 1'bx, expseq[i]);
            else passes++;
        end
        checks++; if (sr !== 4'b0110) $display("FAIL midrst_shreg_out: got %b want 0110", sr); else passes++;
    endtask

    task test_back_to_back;
        int span, gap;
`ifdef BSR_FEED_SKID_EN
        span = 7; gap = 4;
`else
        span = 8; gap = 5;
`endif
        clear_mon(); exp_dir = 1'b0; expseq = 8'h5A;
        send(4'hA, 1'b0);
        send(4'h5, 1'b0);
        in_valid = 1'b0;
        drain();
        for (int i = 0; i < 3; i++) tick();
        checks++; if (en_cnt !== 8) $display("FAIL b2b_en_cnt: got %0d want 8", en_cnt); else passes++;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= dq.size() || dq[i] !== expseq[i]) $display("FAIL b2b_bit%0d: got %b want %b", i, (i < dq.size()) ? dq[i] : 1'bx, expseq[i]);
            else passes++;
        end
        checks++; if (last_en - first_en !== span) $display("FAIL b2b_span: got %0d want %0d", last_en - first_en, span); else passes++;
        checks++; if (wd.size() !== 2) $display("FAIL b2b_wd_count: got %0d want 2", wd.size()); else passes++;
        checks++; if (wd.size() < 2 || wd[1] - wd[0] !== gap) $display("FAIL b2b_wd_gap: got %0d want %0d", (wd.size() < 2) ? -1 : wd[1] - wd[0], gap); else passes++;
    endtask

    task test_hold_last;
        clear_mon(); exp_dir = 1'b1;
        send(4'b0110, 1'b1);
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        hold = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (s_wd !== 1'b0 || s_en !== 1'b0) $display("FAIL holdlast_wd%0d: wd=%b en=%b want 0 0", i, s_wd, s_en); else passes++;
            checks++; if (s_busy !== 1'b1) $display("FAIL holdlast_busy%0d: got %b want 1", i, s_busy); else passes++;
        end
        hold = 1'b0;
        tick();
        checks++; if (s_wd !== 1'b1 || s_en !== 1'b1) $display("FAIL holdlast_release: wd=%b en=%b want 1 1", s_wd, s_en); else passes++;
        tick();
        checks++; if (s_busy !== 1'b0) $display("FAIL holdlast_idle: busy=%b want 0", s_busy); else passes++;
        checks++; if (en_cnt !== 4 || wd.size() !== 1) $display("FAIL holdlast_counts: en=%0d wd=%0d want 4 1", en_cnt, wd.size()); else passes++;
        checks++; if (dq.size() < 4 || dq[3] !== 1'b0) $display("FAIL holdlast_bit3: got %b want 0", (dq.size() < 4) ? 1'bx : dq[3]); else passes++;
    endtask

    initial begin
        cyc = 0; acc_cyc = 0; exp_dir = 1'b0;
        clear_mon();
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        test_hold_last();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
